// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: one-cold row drive, per-frame key resolution, frame debounce,
// and an accepted-state FSM producing key strobe, held and multi-key status.
module keypad_scan_debounce #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [COLS-1:0]              col_n,
  output logic [ROWS-1:0]              row_n,
  output logic [$clog2(ROWS*COLS)-1:0] key_code,
  output logic                         key_valid,
  output logic                         key_held,
  output logic                         multi_key
);

  localparam int unsigned CW = $clog2(ROWS*COLS);
  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned SW = $clog2(DEBOUNCE+1);

  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_e;
  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_MULTI} state_e;

  logic [DW-1:0]   dwell_q;
  logic [RW-1:0]   row_q;
  logic [RW-1:0]   row_nxt;
  logic [ROWS-1:0] row_n_nxt;
  logic            sample;
  logic            last_row;
  logic            frame_eval;

  assign sample     = (dwell_q == DW'(SCAN_DIV-1));
  assign last_row   = (row_q == RW'(ROWS-1));
  assign frame_eval = sample & last_row;
  assign row_nxt    = last_row ? '0 : row_q + RW'(1);

  // One-cold decode of the next row so row_n switches in a single registered step
  always_comb begin
    row_n_nxt          = '1;
    row_n_nxt[row_nxt] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
      row_q   <= '0;
      row_n   <= ~ROWS'(1);
    end else if (sample) begin
      dwell_q <= '0;
      row_q   <= row_nxt;
      row_n   <= row_n_nxt;
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  // Column sense: any closure, more than one closure, and the closed column index
  logic          any_closed;
  logic          many_closed;
  logic [CW-1:0] col_idx;
  logic [CW-1:0] sample_code;

  always_comb begin
    any_closed  = 1'b0;
    many_closed = 1'b0;
    col_idx     = '0;
    for (int i = 0; i < COLS; i++) begin
      if (!col_n[i]) begin
        many_closed = many_closed | any_closed;
        any_closed  = 1'b1;
        col_idx     = CW'(i);
      end
    end
  end

  assign sample_code = CW'(row_q) * CW'(COLS) + col_idx;

  frame_e        acc_kind_q, acc_kind_nx, prev_kind_q;
  logic [CW-1:0] acc_code_q, acc_code_nx, prev_code_q;
  logic [SW-1:0] stable_q, stable_nx;

  always_comb begin
    acc_kind_nx = acc_kind_q;
    acc_code_nx = acc_code_q;
    if (any_closed) begin
      if (!many_closed && acc_kind_q == FR_NONE) begin
        acc_kind_nx = FR_SINGLE;
        acc_code_nx = sample_code;
      end else begin
        acc_kind_nx = FR_MULTI;
        acc_code_nx = '0;
      end
    end
  end

  always_comb begin
    stable_nx = SW'(1);
    if (acc_kind_nx == prev_kind_q && acc_code_nx == prev_code_q) begin
      stable_nx = (stable_q == SW'(DEBOUNCE)) ? stable_q : stable_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_kind_q  <= FR_NONE;
      acc_code_q  <= '0;
      prev_kind_q <= FR_NONE;
      prev_code_q <= '0;
      stable_q    <= '0;
    end else if (sample) begin
      if (last_row) begin
        acc_kind_q  <= FR_NONE;
        acc_code_q  <= '0;
        prev_kind_q <= acc_kind_nx;
        prev_code_q <= acc_code_nx;
        stable_q    <= stable_nx;
      end else begin
        acc_kind_q <= acc_kind_nx;
        acc_code_q <= acc_code_nx;
      end
    end
  end

  state_e        state_q, state_d;
  logic          differs;
  logic          accept;
  logic [CW-1:0] key_code_d;
  logic          key_valid_d, key_held_d, multi_key_d;

  // Debounced frame versus the currently accepted state
  always_comb begin
    differs = 1'b0;
    case (state_q)
      S_IDLE:    differs = (acc_kind_nx != FR_NONE);
      S_PRESSED: differs = !(acc_kind_nx == FR_SINGLE && acc_code_nx == key_code);
      S_MULTI:   differs = (acc_kind_nx != FR_MULTI);
      default:   differs = 1'b1;
    endcase
  end

  assign accept = frame_eval && (stable_nx == SW'(DEBOUNCE)) && differs;

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code;
    key_valid_d = 1'b0;
    key_held_d  = key_held;
    multi_key_d = multi_key;
    if (accept) begin
      case (acc_kind_nx)
        FR_SINGLE: begin
          state_d     = S_PRESSED;
          key_code_d  = acc_code_nx;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          multi_key_d = 1'b0;
        end
        FR_MULTI: begin
          state_d     = S_MULTI;
          key_held_d  = 1'b0;
          multi_key_d = 1'b1;
        end
        default: begin
          state_d     = S_IDLE;
          key_held_d  = 1'b0;
          multi_key_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
      multi_key <= multi_key_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: keypad matrix model on the row/column lines, a
// frame-level reference model checked every cycle, and directed scenarios with fixed timing.
module tb_keypad_scan_debounce;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid, key_held, multi_key;

  logic [3:0] pressed [4];

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  keypad_scan_debounce #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to its row while that row is driven low
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_n[r]) col_n = col_n & ~pressed[r];
    end
  end

  // Reference model: count closures per frame, then track runs of identical frame results.
  // Frame result encoding: -1 none, -2 several keys, otherwise the key number.
  int cyc = 0;
  int m_hits = 0, m_key = 0, m_last = -1, m_run = 0, m_acc = -1, m_res = 0, m_row = 0;
  int exp_code = 0, exp_valid = 0, exp_held = 0, exp_multi = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_hits = 0; m_key = 0; m_last = -1; m_run = 0; m_acc = -1;
      exp_code = 0; exp_valid = 0; exp_held = 0; exp_multi = 0;
    end else begin
      cyc++;
      exp_valid = 0;
      if (cyc % SCAN_DIV == 0) begin
        m_row = (cyc / SCAN_DIV - 1) % ROWS;
        for (int c = 0; c < COLS; c++) begin
          if (pressed[m_row][c]) begin
            m_hits++;
            m_key = m_row * COLS + c;
          end
        end
        if (m_row == ROWS - 1) begin
          m_res = (m_hits == 0) ? -1 : (m_hits == 1) ? m_key : -2;
          if (m_res == m_last) m_run++;
          else begin m_run = 1; m_last = m_res; end
          if (m_run >= DEBOUNCE && m_res != m_acc) begin
            m_acc = m_res;
            if (m_res >= 0) begin
              exp_code = m_res; exp_valid = 1; exp_held = 1; exp_multi = 0;
            end else if (m_res == -2) begin
              exp_held = 0; exp_multi = 1;
            end else begin
              exp_held = 0; exp_multi = 0;
            end
          end
          m_hits = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  logic [3:0] exp_row_n;

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    exp_row_n = ~(4'b0001 << ((cyc / SCAN_DIV) % ROWS));
    chk("row_n", row_n, exp_row_n);
    chk("key_valid", key_valid, exp_valid);
    chk("key_code", key_code, exp_code);
    chk("key_held", key_held, exp_held);
    chk("multi_key", multi_key, exp_multi);
    if (key_valid === 1'b1) pulses++;
  end

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_row_n"}, row_n, 4'b1110);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_held"}, key_held, 0);
    chk({tag, "_multi"}, multi_key, 0);
    chk({tag, "_code"}, key_code, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < ROWS; r++) pressed[r] = 4'b0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    #1 rst_n = 1'b1;

    // Row drive sequence after release
    chk("row_c0", row_n, 4'b1110);
    goto(4);  chk("row_c4", row_n, 4'b1101);
    goto(8);  chk("row_c8", row_n, 4'b1011);
    goto(12); chk("row_c12", row_n, 4'b0111);
    goto(16); chk("row_c16", row_n, 4'b1110);

    // Steady press r2,c1
    goto(20); pressed[2][1] = 1'b1;
    goto(63); chk("k9_pre", key_valid, 0);
    goto(64);
    chk("k9_valid", key_valid, 1); chk("k9_code", key_code, 9); chk("k9_held", key_held, 1);
    chk("model_k9_valid", exp_valid, 1); chk("model_k9_code", exp_code, 9);
    goto(65);  chk("k9_post", key_valid, 0);
    goto(120); chk("k9_hold", key_held, 1); chk("k9_pulses", pulses, 1);
    pressed[2][1] = 1'b0;
    goto(159); chk("k9_rel_pre", key_held, 1);
    goto(160); chk("k9_rel", key_held, 0); chk("k9_code_kept", key_code, 9);

    // Bounce on r0,c3 then hold
    for (int k = 0; k < 10; k++) begin
      goto(172 + 10 * k);
      pressed[0][3] = (k % 2 == 0);
    end
    goto(272); pressed[0][3] = 1'b1;
    goto(303); chk("k3_no_bounce_pulse", pulses, 1); chk("k3_pre", key_valid, 0);
    goto(304);
    chk("k3_valid", key_valid, 1); chk("k3_code", key_code, 3);
    chk("model_k3_valid", exp_valid, 1);
    goto(320); pressed[0][3] = 1'b0;
    goto(368); chk("k3_rel", key_held, 0);

    // Two keys together, then one released
    goto(384); pressed[1][0] = 1'b1; pressed[3][2] = 1'b1;
    goto(431); chk("multi_pre", multi_key, 0);
    goto(432);
    chk("multi_on", multi_key, 1); chk("multi_held", key_held, 0);
    chk("model_multi", exp_multi, 1);
    goto(440); chk("multi_no_pulse", pulses, 2);
    goto(448); pressed[3][2] = 1'b0;
    goto(496);
    chk("k4_valid", key_valid, 1); chk("k4_code", key_code, 4);
    chk("k4_held", key_held, 1); chk("k4_multi", multi_key, 0);
    goto(512); pressed[1][0] = 1'b0;
    goto(560); chk("k4_rel", key_held, 0);

    // Key 15: press, release, re-press
    goto(576); pressed[3][3] = 1'b1;
    goto(624); chk("k15a_valid", key_valid, 1); chk("k15a_code", key_code, 15);
    goto(640); pressed[3][3] = 1'b0;
    goto(688);
    chk("k15_rel_held", key_held, 0); chk("k15_rel_code", key_code, 15);
    goto(704); pressed[3][3] = 1'b1;
    goto(752); chk("k15b_valid", key_valid, 1); chk("k15b_code", key_code, 15);
    goto(760); chk("k15_pulses", pulses, 5);
    goto(768); pressed[3][3] = 1'b0;
    goto(816); chk("k15b_rel", key_held, 0);

    // Reset in the middle of debouncing key 6
    goto(832); pressed[1][2] = 1'b1;
    goto(870); chk("k6_no_pulse", pulses, 5);
    #1 rst_n = 1'b0;
    #1 chk_reset_state("midrst");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    goto(47); chk("k6_pre", key_valid, 0);
    goto(48);
    chk("k6_valid", key_valid, 1); chk("k6_code", key_code, 6);
    chk("model_k6_code", exp_code, 6);
    goto(64); chk("k6_pulses", pulses, 6); chk("k6_held", key_held, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
